quiz_round_control: RTL and testbench

- Sequences one quiz game using the host settings: question rounds, buzz-in arbitration, answer countdown, scoring, and end-of-game winner.
- Sits between the debounced input edges (player buzzers, host buttons), the 1 Hz tick, and the display/view logic.
- Arbitrates the answering slot between up to 4 player requesters with rotating priority.

---
 rtl/quiz_round_control_if.sv | 38 +++
 rtl/quiz_round_control.sv | 221 ++++++++++++++++++++++
 tb/tb_quiz_round_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quiz_round_control_if.sv
// Settings, pulse inputs and display outputs of one quiz_round_control.
// Every input pulse (start, buzz, judge_*, tick_1hz) is a single-cycle strobe with no backpressure.
interface quiz_round_control_if #(
    parameter int NP = 4,
    parameter int SW = 7
);
    logic [2:0]         player_count;
    logic [3:0]         question_count;
    logic [6:0]         answer_time;
    logic [SW-1:0]      win_score;
    logic [3:0]         success_score;
    logic [3:0]         fail_score;
    logic               start;
    logic [NP-1:0]      buzz;
    logic               judge_ok;
    logic               judge_fail;
    logic               tick_1hz;

    logic [2:0]         phase;
    logic [1:0]         answerer;
    logic [6:0]         time_left;
    logic [3:0]         question_no;
    logic [NP-1:0]      lockout;
    logic [NP*SW-1:0]   scores;
    logic [1:0]         winner;

    modport master (
        output player_count, question_count, answer_time, win_score,
        output success_score, fail_score, start, buzz, judge_ok, judge_fail, tick_1hz,
        input  phase, answerer, time_left, question_no, lockout, scores, winner
    );

    modport slave (
        input  player_count, question_count, answer_time, win_score,
        input  success_score, fail_score, start, buzz, judge_ok, judge_fail, tick_1hz,
        output phase, answerer, time_left, question_no, lockout, scores, winner
    );
endinterface

// File: rtl/quiz_round_control.sv
// Quiz game sequencer: rounds, rotating-priority buzz arbitration, countdown, scoring, winner.
// Define FALSE_START_EN to add a 3-second ARM window that penalises early buzzes.
module quiz_round_control #(
    parameter int NP = 4,
    parameter int SW = 7
) (
    input logic                 clk,
    input logic                 rst,
    quiz_round_control_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_READY  = 3'd2,
        S_ANSWER = 3'd3,
        S_NEXT   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             answerer_q, answerer_d;
    logic [6:0]             time_left_q, time_left_d;
    logic [3:0]             question_no_q, question_no_d;
    logic [NP-1:0]          lockout_q, lockout_d;
    logic [NP-1:0][SW-1:0]  scores_q, scores_d;
    logic [1:0]             winner_q, winner_d;
    logic [2:0]             pcount_q, pcount_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;

    logic [NP-1:0]          active, eligible;
    logic                   grant_found;
    logic [1:0]             grant_idx, grant_next;
    logic                   win_hit;
    logic [1:0]             win_idx, best_idx;
    logic [SW-1:0]          best_val;
    logic                   counting, timeout;

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] s, input logic [3:0] d);
        logic [SW:0] sum;
        sum = {1'b0, s} + (SW+1)'(d);
        return sum[SW] ? '1 : sum[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] floor_sub(input logic [SW-1:0] s, input logic [3:0] d);
        logic [SW-1:0] dd;
        dd = SW'(d);
        return (s < dd) ? '0 : s - dd;
    endfunction

    always_comb begin : active_mask
        for (int i = 0; i < NP; i++) active[i] = (3'(i) < pcount_q);
    end

    assign eligible = bus.buzz & active & ~lockout_q;

    // Search order starts at rr_ptr and wraps modulo the latched player count.
    always_comb begin : rr_grant
        logic [2:0] cand;
        logic [2:0] nxt;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NP; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= pcount_q) cand = cand - pcount_q;
            if (!grant_found && (3'(k) < pcount_q) && eligible[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
        nxt        = {1'b0, grant_idx} + 3'd1;
        grant_next = (nxt >= pcount_q) ? 2'd0 : nxt[1:0];
    end

    always_comb begin : score_scan
        win_hit  = 1'b0;
        win_idx  = '0;
        best_idx = '0;
        best_val = scores_q[0];
        for (int i = 0; i < NP; i++) begin
            if (!win_hit && (scores_q[i] >= bus.win_score)) begin
                win_hit = 1'b1;
                win_idx = 2'(i);
            end
            if (scores_q[i] > best_val) begin
                best_val = scores_q[i];
                best_idx = 2'(i);
            end
        end
    end

    always_comb begin : next_state
        state_d       = state_q;
        answerer_d    = answerer_q;
        time_left_d   = time_left_q;
        question_no_d = question_no_q;
        lockout_d     = lockout_q;
        scores_d      = scores_q;
        winner_d      = winner_q;
        pcount_d      = pcount_q;
        rr_ptr_d      = rr_ptr_q;

        counting = (state_q == S_ARM) || (state_q == S_READY) || (state_q == S_ANSWER);
        timeout  = counting && bus.tick_1hz && (time_left_q == 7'd1);
        if (counting && bus.tick_1hz && (time_left_q != 7'd0)) time_left_d = time_left_q - 7'd1;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    pcount_d      = bus.player_count;
                    scores_d      = '0;
                    question_no_d = 4'd1;
                    lockout_d     = '0;
                    rr_ptr_d      = '0;
`ifdef FALSE_START_EN
                    state_d       = S_ARM;
                    time_left_d   = 7'd3;
`else
                    state_d       = S_READY;
                    time_left_d   = bus.answer_time;
`endif
                end
            end
`ifdef FALSE_START_EN
            S_ARM: begin
                for (int i = 0; i < NP; i++) begin
                    if (eligible[i]) begin
                        scores_d[i]  = floor_sub(scores_q[i], bus.fail_score);
                        lockout_d[i] = 1'b1;
                    end
                end
                if (timeout) begin
                    if ((lockout_d & active) == active) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d     = S_READY;
                        time_left_d = bus.answer_time;
                    end
                end
            end
`endif
            S_READY: begin
                if (grant_found) begin
                    answerer_d  = grant_idx;
                    rr_ptr_d    = grant_next;
                    state_d     = S_ANSWER;
                    time_left_d = bus.answer_time;
                end else if (timeout) begin
                    state_d = S_NEXT;
                end
            end
            S_ANSWER: begin
                if (bus.judge_ok) begin
                    scores_d[answerer_q] = sat_add(scores_q[answerer_q], bus.success_score);
                    state_d              = S_NEXT;
                end else if (bus.judge_fail || timeout) begin
                    scores_d[answerer_q]  = floor_sub(scores_q[answerer_q], bus.fail_score);
                    lockout_d[answerer_q] = 1'b1;
                    if ((lockout_d & active) == active) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d     = S_READY;
                        time_left_d = bus.answer_time;
                    end
                end
            end
            S_NEXT: begin
                if (win_hit) begin
                    state_d  = S_OVER;
                    winner_d = win_idx;
                end else if (question_no_q == bus.question_count) begin
                    state_d  = S_OVER;
                    winner_d = best_idx;
                end else begin
                    question_no_d = question_no_q + 4'd1;
                    lockout_d     = '0;
`ifdef FALSE_START_EN
                    state_d       = S_ARM;
                    time_left_d   = 7'd3;
`else
                    state_d       = S_READY;
                    time_left_d   = bus.answer_time;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            answerer_q    <= '0;
            time_left_q   <= '0;
            question_no_q <= '0;
            lockout_q     <= '0;
            scores_q      <= '0;
            winner_q      <= '0;
            pcount_q      <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            answerer_q    <= answerer_d;
            time_left_q   <= time_left_d;
            question_no_q <= question_no_d;
            lockout_q     <= lockout_d;
            scores_q      <= scores_d;
            winner_q      <= winner_d;
            pcount_q      <= pcount_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.phase       = state_q;
    assign bus.answerer    = answerer_q;
    assign bus.time_left   = time_left_q;
    assign bus.question_no = question_no_q;
    assign bus.lockout     = lockout_q;
    assign bus.scores      = scores_q;
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_quiz_round_control.sv
// Bench for quiz_round_control: scripted vector table, hand-built corner sequences,
// then random play checked against a game-level reference model.
module tb_quiz_round_control;
    localparam int NP   = 4;
    localparam int SW   = 7;
    localparam int W    = 3 + 2 + 7 + 4 + NP + NP * SW + 2;
    localparam int MAXS = (1 << SW) - 1;
    localparam int P_IDLE = 0, P_ARM = 1, P_READY = 2, P_ANSWER = 3, P_NEXT = 4, P_OVER = 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    quiz_round_control_if #(.NP(NP), .SW(SW)) bus ();
    quiz_round_control #(.NP(NP), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    int c_pc, c_qc, c_at, c_ws, c_ss, c_fs;

    // game-level reference model
    int m_ph, m_ans, m_tl, m_qn, m_win, m_pc, m_rr;
    int m_sc[NP];
    bit m_lk[NP];

    typedef struct {
        bit st; bit [3:0] bz; bit ok; bit fl; bit tk;
        int ph; int ans; int tl; int qn; bit [3:0] lk;
        int s0; int s1; int s2; int win;
    } vec_t;
    vec_t vt[19];

    function automatic logic [W-1:0] pk(int ph, int ans, int tl, int qn, logic [NP-1:0] lk,
                                        int s0, int s1, int s2, int s3, int win);
        logic [NP*SW-1:0] sc;
        sc = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
        return {3'(ph), 2'(ans), 7'(tl), 4'(qn), lk, sc, 2'(win)};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {bus.phase, bus.answerer, bus.time_left, bus.question_no, bus.lockout, bus.scores, bus.winner};
    endfunction

    function automatic string fmt(logic [W-1:0] v);
        return $sformatf("ph=%0d ans=%0d tl=%0d qn=%0d lk=%b sc=%h win=%0d",
                         v[W-1 -: 3], v[W-4 -: 2], v[W-6 -: 7], v[W-13 -: 4],
                         v[W-17 -: NP], v[2 +: NP*SW], v[1:0]);
    endfunction

    task automatic check_vec(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(got), fmt(exp));
        end
    endtask

    task automatic apply_cfg();
        bus.player_count   = 3'(c_pc);
        bus.question_count = 4'(c_qc);
        bus.answer_time    = 7'(c_at);
        bus.win_score      = SW'(c_ws);
        bus.success_score  = 4'(c_ss);
        bus.fail_score     = 4'(c_fs);
    endtask

    task automatic set_cfg(input int pc, qc, at, ws, ss, fs);
        c_pc = pc; c_qc = qc; c_at = at; c_ws = ws; c_ss = ss; c_fs = fs;
        apply_cfg();
    endtask

    // driver: inputs change 1 time unit after a rising edge, outputs sampled there too
    task automatic drive(input bit st, input bit [NP-1:0] bz, input bit ok, fl, tk);
        bus.start = st; bus.buzz = bz; bus.judge_ok = ok; bus.judge_fail = fl; bus.tick_1hz = tk;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.buzz = '0; bus.judge_ok = 1'b0; bus.judge_fail = 1'b0; bus.tick_1hz = 1'b0;
    endtask

    task automatic step(input string nm, input bit st, input bit [NP-1:0] bz, input bit ok, fl, tk,
                        input logic [W-1:0] exp);
        exp_q.push_back(exp);
        drive(st, bz, ok, fl, tk);
        check_vec(nm, dut_vec(), exp_q.pop_front());
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.buzz = '0; bus.judge_ok = 1'b0; bus.judge_fail = 1'b0; bus.tick_1hz = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_ans = 0; m_tl = 0; m_qn = 0; m_win = 0; m_pc = 0; m_rr = 0;
        for (int i = 0; i < NP; i++) begin m_sc[i] = 0; m_lk[i] = 0; end
    endtask

    task automatic open_question();
`ifdef FALSE_START_EN
        m_ph = P_ARM; m_tl = 3;
`else
        m_ph = P_READY; m_tl = c_at;
`endif
    endtask

    task automatic penalize(input int p);
        m_sc[p] = (m_sc[p] < c_fs) ? 0 : m_sc[p] - c_fs;
        m_lk[p] = 1;
    endtask

    function automatic bit all_locked();
        for (int i = 0; i < m_pc; i++) if (!m_lk[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit st, input bit [NP-1:0] bz, input bit ok, fl, tk);
        bit counting, tmo;
        int order[$];
        int pick, w, best;
        counting = (m_ph == P_ARM) || (m_ph == P_READY) || (m_ph == P_ANSWER);
        tmo = counting && tk && (m_tl == 1);
        if (counting && tk && m_tl > 0) m_tl = m_tl - 1;
        case (m_ph)
            P_IDLE, P_OVER: if (st) begin
                m_pc = c_pc; m_qn = 1; m_rr = 0;
                for (int i = 0; i < NP; i++) begin m_sc[i] = 0; m_lk[i] = 0; end
                open_question();
            end
            P_ARM: begin
                for (int i = 0; i < m_pc; i++) if (bz[i] && !m_lk[i]) penalize(i);
                if (tmo) begin
                    if (all_locked()) m_ph = P_NEXT;
                    else begin m_ph = P_READY; m_tl = c_at; end
                end
            end
            P_READY: begin
                pick = -1;
                for (int k = 0; k < m_pc; k++) order.push_back((m_rr + k) % m_pc);
                foreach (order[j]) if (pick < 0 && bz[order[j]] && !m_lk[order[j]]) pick = order[j];
                if (pick >= 0) begin
                    m_ans = pick; m_rr = (pick + 1) % m_pc; m_ph = P_ANSWER; m_tl = c_at;
                end else if (tmo) m_ph = P_NEXT;
            end
            P_ANSWER: begin
                if (ok) begin
                    m_sc[m_ans] = (m_sc[m_ans] + c_ss > MAXS) ? MAXS : m_sc[m_ans] + c_ss;
                    m_ph = P_NEXT;
                end else if (fl || tmo) begin
                    penalize(m_ans);
                    if (all_locked()) m_ph = P_NEXT;
                    else begin m_ph = P_READY; m_tl = c_at; end
                end
            end
            P_NEXT: begin
                w = -1; best = 0;
                for (int i = 0; i < NP; i++) begin
                    if (w < 0 && m_sc[i] >= c_ws) w = i;
                    if (m_sc[i] > m_sc[best]) best = i;
                end
                if (w >= 0) begin m_ph = P_OVER; m_win = w; end
                else if (m_qn == c_qc) begin m_ph = P_OVER; m_win = best; end
                else begin
                    m_qn++;
                    for (int i = 0; i < NP; i++) m_lk[i] = 0;
                    open_question();
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [NP-1:0] lk;
        for (int i = 0; i < NP; i++) lk[i] = m_lk[i];
        return pk(m_ph, m_ans, m_tl, m_qn, lk, m_sc[0], m_sc[1], m_sc[2], m_sc[3], m_win);
    endfunction

    task automatic rand_cfg();
        c_pc = $urandom_range(2, NP);
        c_qc = $urandom_range(1, 4);
        c_at = $urandom_range(1, 6);
        c_ws = ($urandom_range(0, 3) == 0) ? $urandom_range(120, 127) : $urandom_range(3, 30);
        c_ss = $urandom_range(0, 15);
        c_fs = $urandom_range(0, 15);
        apply_cfg();
    endtask

    initial begin
        set_cfg(3, 3, 5, 100, 2, 3);
        do_reset();
        check_vec("reset_state", dut_vec(), pk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

`ifndef FALSE_START_EN
        // scripted game: st bz ok fl tk | ph ans tl qn lk s0 s1 s2 win
        vt[0]  = '{1, 4'b0000, 0, 0, 0, 2, 0, 5, 1, 4'b0000, 0, 0, 0, 0};
        vt[1]  = '{0, 4'b0110, 0, 0, 0, 3, 1, 5, 1, 4'b0000, 0, 0, 0, 0};
        vt[2]  = '{0, 4'b0000, 1, 0, 0, 4, 1, 5, 1, 4'b0000, 0, 2, 0, 0};
        vt[3]  = '{0, 4'b0000, 0, 0, 0, 2, 1, 5, 2, 4'b0000, 0, 2, 0, 0};
        vt[4]  = '{0, 4'b0111, 0, 0, 0, 3, 2, 5, 2, 4'b0000, 0, 2, 0, 0};
        vt[5]  = '{0, 4'b0000, 0, 1, 0, 2, 2, 5, 2, 4'b0100, 0, 2, 0, 0};
        vt[6]  = '{1, 4'b0000, 0, 0, 1, 2, 2, 4, 2, 4'b0100, 0, 2, 0, 0};
        vt[7]  = '{0, 4'b0100, 0, 0, 0, 2, 2, 4, 2, 4'b0100, 0, 2, 0, 0};
        vt[8]  = '{0, 4'b0101, 0, 0, 0, 3, 0, 5, 2, 4'b0100, 0, 2, 0, 0};
        vt[9]  = '{0, 4'b0000, 0, 0, 1, 3, 0, 4, 2, 4'b0100, 0, 2, 0, 0};
        vt[10] = '{0, 4'b0000, 1, 0, 0, 4, 0, 4, 2, 4'b0100, 2, 2, 0, 0};
        vt[11] = '{0, 4'b0000, 0, 0, 0, 2, 0, 5, 3, 4'b0000, 2, 2, 0, 0};
        vt[12] = '{0, 4'b1000, 0, 0, 0, 2, 0, 5, 3, 4'b0000, 2, 2, 0, 0};
        vt[13] = '{0, 4'b0001, 0, 0, 0, 3, 0, 5, 3, 4'b0000, 2, 2, 0, 0};
        vt[14] = '{0, 4'b0000, 0, 1, 0, 2, 0, 5, 3, 4'b0001, 0, 2, 0, 0};
        vt[15] = '{0, 4'b0011, 0, 0, 0, 3, 1, 5, 3, 4'b0001, 0, 2, 0, 0};
        vt[16] = '{0, 4'b0000, 1, 0, 0, 4, 1, 5, 3, 4'b0001, 0, 4, 0, 0};
        vt[17] = '{0, 4'b0000, 0, 0, 0, 5, 1, 5, 3, 4'b0001, 0, 4, 0, 1};
        vt[18] = '{0, 4'b0111, 1, 1, 1, 5, 1, 5, 3, 4'b0001, 0, 4, 0, 1};
        for (int i = 0; i < 19; i++) begin
            step($sformatf("vec%0d", i), vt[i].st, vt[i].bz, vt[i].ok, vt[i].fl, vt[i].tk,
                 pk(vt[i].ph, vt[i].ans, vt[i].tl, vt[i].qn, vt[i].lk, vt[i].s0, vt[i].s1, vt[i].s2, 0, vt[i].win));
        end

        // answer timeout, then READY timeout
        do_reset();
        set_cfg(3, 9, 2, 100, 2, 3);
        step("to_start",  1, 4'b0000, 0, 0, 0, pk(2, 0, 2, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("to_grant",  0, 4'b0001, 0, 0, 0, pk(3, 0, 2, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("to_tick1",  0, 4'b0000, 0, 0, 1, pk(3, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("to_tick2",  0, 4'b0000, 0, 0, 1, pk(2, 0, 2, 1, 4'b0001, 0, 0, 0, 0, 0));
        step("rdy_tick1", 0, 4'b0000, 0, 0, 1, pk(2, 0, 1, 1, 4'b0001, 0, 0, 0, 0, 0));
        step("rdy_tmo",   0, 4'b0000, 0, 0, 1, pk(4, 0, 0, 1, 4'b0001, 0, 0, 0, 0, 0));
        step("rdy_next",  0, 4'b0000, 0, 0, 0, pk(2, 0, 2, 2, 4'b0000, 0, 0, 0, 0, 0));

        // immediate win on reaching win_score
        do_reset();
        set_cfg(3, 9, 5, 3, 3, 1);
        step("win_start", 1, 4'b0000, 0, 0, 0, pk(2, 0, 5, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("win_grant", 0, 4'b0010, 0, 0, 0, pk(3, 1, 5, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("win_ok",    0, 4'b0000, 1, 0, 0, pk(4, 1, 5, 1, 4'b0000, 0, 3, 0, 0, 0));
        step("win_over",  0, 4'b0000, 0, 0, 0, pk(5, 1, 5, 1, 4'b0000, 0, 3, 0, 0, 1));

        // last question reached with a 2/2 tie between players 1 and 2
        do_reset();
        set_cfg(3, 3, 1, 100, 2, 1);
        step("tie_start", 1, 4'b0000, 0, 0, 0, pk(2, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("tie_g1",    0, 4'b0010, 0, 0, 0, pk(3, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("tie_ok1",   0, 4'b0000, 1, 0, 0, pk(4, 1, 1, 1, 4'b0000, 0, 2, 0, 0, 0));
        step("tie_q2",    0, 4'b0000, 0, 0, 0, pk(2, 1, 1, 2, 4'b0000, 0, 2, 0, 0, 0));
        step("tie_g2",    0, 4'b0100, 0, 0, 0, pk(3, 2, 1, 2, 4'b0000, 0, 2, 0, 0, 0));
        step("tie_ok2",   0, 4'b0000, 1, 0, 0, pk(4, 2, 1, 2, 4'b0000, 0, 2, 2, 0, 0));
        step("tie_q3",    0, 4'b0000, 0, 0, 0, pk(2, 2, 1, 3, 4'b0000, 0, 2, 2, 0, 0));
        step("tie_tmo",   0, 4'b0000, 0, 0, 1, pk(4, 2, 0, 3, 4'b0000, 0, 2, 2, 0, 0));
        step("tie_over",  0, 4'b0000, 0, 0, 0, pk(5, 2, 0, 3, 4'b0000, 0, 2, 2, 0, 1));

        // asynchronous reset in the middle of ANSWER
        do_reset();
        set_cfg(3, 9, 5, 100, 2, 1);
        step("ar_start",  1, 4'b0000, 0, 0, 0, pk(2, 0, 5, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("ar_grant",  0, 4'b0001, 0, 0, 0, pk(3, 0, 5, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("ar_ok",     0, 4'b0000, 1, 0, 0, pk(4, 0, 5, 1, 4'b0000, 2, 0, 0, 0, 0));
        step("ar_q2",     0, 4'b0000, 0, 0, 0, pk(2, 0, 5, 2, 4'b0000, 2, 0, 0, 0, 0));
        step("ar_grant2", 0, 4'b0010, 0, 0, 0, pk(3, 1, 5, 2, 4'b0000, 2, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check_vec("async_reset", dut_vec(), pk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("after_reset", 0, 4'b0011, 1, 0, 1, pk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
`endif

        // random play against the reference model
        do_reset();
        model_reset();
        rand_cfg();
        for (int c = 0; c < 4000; c++) begin
            bit st, ok, fl, tk;
            bit [NP-1:0] bz;
            if (($urandom_range(0, 99) == 0) ||
                (((m_ph == P_IDLE) || (m_ph == P_OVER)) && ($urandom_range(0, 3) == 0))) rand_cfg();
            st = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NP; i++) bz[i] = ($urandom_range(0, 5) == 0);
            ok = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 2) == 0);
            model_step(st, bz, ok, fl, tk);
            exp_q.push_back(model_vec());
            drive(st, bz, ok, fl, tk);
            check_vec($sformatf("rand%0d", c), dut_vec(), exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
